melody_sequencer: RTL
=====================

# melody_sequencer

Note-sequencing controller for the square-wave tone generator. Steps through a 16-entry melody held in a parameter and drives the generator's half-period reload value and enable for each note's duration. Inserts a short silent gap between notes, and supports play, stop and looped playback. Sits between user controls and the speaker divider, which reloads its counter with `half_period - 1` while `tone_en` is high.

## Interface
- `CLK_HZ`, 25000000: system clock frequency; documents the note table below. The table is fixed for 25 MHz.
- `TICK_CYCLES`, 1562500: clock cycles per duration tick (1/16 s).
- `GAP_CYCLES`, 250000: silent cycles at the end of each note. Must be less than `TICK_CYCLES`.
- `MELODY`, 128-bit: entry i sits at bits [8i+7:8i], formatted {note[3:0], dur[3:0]}.
  - note 0 = rest; 1..12 = pitch; 13, 14 = rest; 15 = end marker.
  - dur 0 means 16 ticks.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `play` in 1: start request, sampled each cycle.
- `stop` in 1: abort request, sampled each cycle.
- `loop` in 1: restart at entry 0 after the end marker or after entry 15.
- `half_period` out 15: divider half-period count for the current note; 0 for rest.
- `tone_en` out 1: generator enable.
- `note_idx` out 4: index of the current entry.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at natural end of a non-looped melody.

## Operation
- Note table, codes 1..12 (A4..G#5): 28409, 26815, 25310, 23889, 22548, 21283, 20088, 18961, 17897, 16892, 15944, 15049. These are 25 MHz/(2f), rounded.
- States: IDLE, FETCH, NOTE, DONE.
- IDLE:
  - Outputs `tone_en`=0, `busy`=0, `note_idx` held.
  - `play`=1 and `stop`=0: `note_idx` set to 0, go to FETCH.
- FETCH (1 cycle): decode entry `note_idx`.
  - End marker with `loop`=1: `note_idx` set to 0, stay in FETCH.
  - End marker with `loop`=0: go to DONE.
  - Otherwise: load the duration counter with dur×`TICK_CYCLES` − 1, latch `half_period` (0 for a rest code), go to NOTE.
- NOTE:
  - The counter decrements each cycle.
  - `tone_en` = 1 when the entry is a pitch and the counter ≥ `GAP_CYCLES`; otherwise 0.
  - When the counter reaches 0, advance to the next entry and go to FETCH:
    - `note_idx` < 15: increment `note_idx`.
    - `note_idx` = 15 and `loop`=1: wrap `note_idx` to 0.
    - `note_idx` = 15 and `loop`=0: go to DONE instead.
- DONE (1 cycle): `done`=1, then IDLE.
- `stop`=1 in any non-IDLE state: next state IDLE, `tone_en`=0 next cycle, no `done` pulse. `stop` takes priority over `play` and over every transition.
- `play` while `busy`: ignored.
- `loop` is sampled only at the end-marker decision and the entry-15 decision.
- Duration counter: 25 bits minimum (16 × 1562500 < 2^25). No overflow is allowed for legal parameters.

## Timing
- Reset value of every output: `half_period`=0, `tone_en`=0, `note_idx`=0, `busy`=0, `done`=0. State = IDLE.
- Reset mid-playback behaves the same as reset from IDLE.
- All outputs are registered.
- Sequence after `play` is sampled high in IDLE:
  - Cycle 1: FETCH, `busy`=1.
  - Cycle 2: first NOTE cycle; `tone_en` and `half_period` are valid.
- Each played entry occupies exactly 1 + dur×`TICK_CYCLES` cycles:
  - The final `GAP_CYCLES` of NOTE have `tone_en`=0.
  - FETCH has `tone_en`=0.
- An end marker costs 1 FETCH cycle, plus 1 DONE cycle when not looping.
- `done` is asserted in the cycle after the terminating FETCH, or after the last NOTE cycle of entry 15; `busy` drops one cycle later.

## Test plan
Test parameters: `TICK_CYCLES`=100, `GAP_CYCLES`=10.

- Basic note: melody {A4 dur1, end}, pulse `play`.
  - `half_period`=28409.
  - `tone_en` high for 90 cycles, then low for 10.
  - `done` pulses exactly 102 cycles after the FETCH-entry cycle; `busy` then falls.
- Rest and pitch change: melody {C5 d2, rest d1, G#5 d1, end}.
  - `tone_en` high for 190 cycles with 23889.
  - `tone_en` low for 10 + 1 + 100 + 1 cycles, with `half_period`=0 during the rest.
  - Then high for 90 cycles with 15049.
- Loop: melody {E5 d1, end}, `loop`=1.
  - `note_idx` cycles 0→1→0.
  - The second E5 starts 102 cycles after the first.
  - `done` is never asserted.
- Stop mid-note: `stop` 40 cycles into a note.
  - Next cycle: `tone_en`=0, `busy`=0, no `done`.
  - A later `play` restarts at `note_idx`=0.
- Full table, no marker: 16 entries of dur 0.
  - Each entry lasts 1601 cycles.
  - `note_idx` runs 0..15, then DONE.
  - With `loop`=1, `note_idx` wraps to 0.
- Contention: `play`+`stop` together in IDLE → stays IDLE.
  - `reset` during NOTE → all outputs 0 the next cycle.
  - `play` during NOTE → ignored.

Source files
------------

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a 16-entry {note, dur} table and drives the square-wave
// divider's half-period and enable, with a silent gap at the tail of every note.
module melody_sequencer #(
  parameter int unsigned  CLK_HZ      = 25000000,
  parameter int unsigned  TICK_CYCLES = 1562500,
  parameter int unsigned  GAP_CYCLES  = 250000,
  parameter logic [127:0] MELODY      = 128'h0000_0000_0000_0000_0000_0000_F084_4414
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        stop,
  input  logic        loop,
  output logic [14:0] half_period,
  output logic        tone_en,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW = $clog2(16 * TICK_CYCLES);

  // The pitch table below holds 25 MHz divider counts.
  if (CLK_HZ != 25000000) begin : g_bad_clk
    $error("melody_sequencer note table assumes a 25 MHz clock");
  end
  if (GAP_CYCLES >= TICK_CYCLES) begin : g_bad_gap
    $error("melody_sequencer GAP_CYCLES must be less than TICK_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StNote, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [14:0]       hp_q, hp_d;
  logic              tone_en_q, tone_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        entry;
  logic [3:0]        entry_note;
  logic [4:0]        dur_ticks;
  logic [CntW-1:0]   cnt_load;

  function automatic logic [14:0] note_hp(input logic [3:0] code);
    case (code)
      4'd1:    note_hp = 15'd28409;
      4'd2:    note_hp = 15'd26815;
      4'd3:    note_hp = 15'd25310;
      4'd4:    note_hp = 15'd23889;
      4'd5:    note_hp = 15'd22548;
      4'd6:    note_hp = 15'd21283;
      4'd7:    note_hp = 15'd20088;
      4'd8:    note_hp = 15'd18961;
      4'd9:    note_hp = 15'd17897;
      4'd10:   note_hp = 15'd16892;
      4'd11:   note_hp = 15'd15944;
      4'd12:   note_hp = 15'd15049;
      default: note_hp = 15'd0;
    endcase
  endfunction

  always_comb begin
    entry      = MELODY[{idx_q, 3'b000} +: 8];
    entry_note = entry[7:4];
    dur_ticks  = (entry[3:0] == 4'd0) ? 5'd16 : {1'b0, entry[3:0]};
    cnt_load   = CntW'(dur_ticks) * CntW'(TICK_CYCLES) - CntW'(1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;

    case (state_q)
      StIdle: begin
        if (play && !stop) begin
          idx_d   = 4'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (entry_note == 4'hF) begin
          if (loop) idx_d = 4'd0;
          else      state_d = StDone;
        end else begin
          cnt_d   = cnt_load;
          hp_d    = note_hp(entry_note);
          state_d = StNote;
        end
      end
      StNote: begin
        if (cnt_q == '0) begin
          if (idx_q != 4'hF) begin
            idx_d   = idx_q + 4'd1;
            state_d = StFetch;
          end else if (loop) begin
            idx_d   = 4'd0;
            state_d = StFetch;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over every other transition and leaves the index where it was.
    if (stop && state_q != StIdle) begin
      state_d = StIdle;
      idx_d   = idx_q;
    end

    // Outputs are registered, so they are derived from the next-state values.
    tone_en_d = (state_d == StNote) && (hp_d != 15'd0) && (cnt_d >= CntW'(GAP_CYCLES));
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      cnt_q     <= '0;
      hp_q      <= 15'd0;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      tone_en_q <= tone_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign half_period = hp_q;
  assign tone_en     = tone_en_q;
  assign note_idx    = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
